// File: rtl/trigger_frame_merger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : trigger_frame_merger
//  Purpose  : Merges framed 64-bit readout streams from N_CH trigger channels
//             onto a single output stream. Channels are granted round-robin at
//             frame granularity: a granted channel owns the output until its
//             footer passes. Words that do not open with a header are dropped,
//             and frames that reach MAX_FRAME_WORDS without a footer are closed
//             with an injected error footer.
//  Ports    : RD_CLK, RD_RESET    - clock, synchronous active-high reset
//             S_DIN/S_VALID       - per-channel input words (channel k at
//                                   [64k+63:64k]) and valids
//             S_READY             - per-channel accept
//             DOUT/oVALID/iREADY  - merged output stream
//             CUR_CH              - channel currently or last granted
//             FRAME_CNT           - frames closed by a normal footer
//             DROP_CNT            - words discarded
//             TIMEOUT_CNT         - error footers injected
//  Revision : 1.0 - initial release
// ============================================================================
module trigger_frame_merger #(
    parameter int         N_CH            = 4,
    parameter int         DATA_WIDTH      = 64,
    parameter int         MAX_FRAME_WORDS = 128,
    parameter logic [7:0] HEADER_ID       = 8'hAA,
    parameter logic [7:0] FOOTER_ID       = 8'h55,
    parameter int         CNT_WIDTH       = 16
) (
    input  logic                         RD_CLK,
    input  logic                         RD_RESET,
    input  logic [N_CH*DATA_WIDTH-1:0]   S_DIN,
    input  logic [N_CH-1:0]              S_VALID,
    output logic [N_CH-1:0]              S_READY,
    output logic [DATA_WIDTH-1:0]        DOUT,
    output logic                         oVALID,
    input  logic                         iREADY,
    output logic [3:0]                   CUR_CH,
    output logic [CNT_WIDTH-1:0]         FRAME_CNT,
    output logic [CNT_WIDTH-1:0]         DROP_CNT,
    output logic [CNT_WIDTH-1:0]         TIMEOUT_CNT
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOCK = 2'd1;
    localparam logic [1:0] c_ST_TERM = 2'd2;

    localparam int c_WCNT_W = $clog2(MAX_FRAME_WORDS + 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_MAX = c_WCNT_W'(MAX_FRAME_WORDS);
    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE = c_WCNT_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_ERR_FOOTER =
        {FOOTER_ID, 8'hEE, {(DATA_WIDTH-16){1'b0}}};

    logic [1:0]             r_state;
    logic [3:0]             r_sel;
    logic [3:0]             r_rr_ptr;
    logic                   r_first;
    logic [c_WCNT_W-1:0]    r_wcnt;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_ovalid;
    logic [CNT_WIDTH-1:0]   r_frame_cnt;
    logic [CNT_WIDTH-1:0]   r_drop_cnt;
    logic [CNT_WIDTH-1:0]   r_timeout_cnt;

    logic [15:0]            w_valid_pad;
    logic                   w_any;
    logic                   w_found;
    logic [3:0]             w_pick;
    logic [3:0]             w_pick_next;
    logic [4:0]             w_idx;
    logic [DATA_WIDTH-1:0]  w_sel_din;
    logic                   w_sel_valid;
    logic                   w_out_free;
    logic                   w_xfer;
    logic                   w_is_hdr;
    logic                   w_is_ftr;
    logic [c_WCNT_W-1:0]    w_wcnt_inc;
    logic [N_CH-1:0]        w_s_ready;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + c_CNT_ONE;
    endfunction

    // Padding to 16 bits lets the 4-bit channel index address any N_CH.
    assign w_valid_pad = 16'(S_VALID);
    assign w_any       = |S_VALID;

    // First valid channel at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_idx = {1'b0, r_rr_ptr} + 5'(i);
            if (w_idx >= 5'(N_CH)) begin
                w_idx = w_idx - 5'(N_CH);
            end
            if (!w_found && w_valid_pad[w_idx[3:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[3:0];
            end
        end
    end

    assign w_pick_next = (w_pick == 4'(N_CH - 1)) ? 4'd0 : w_pick + 4'd1;

    // Data of the granted channel.
    always_comb begin
        w_sel_din = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_sel == 4'(k)) begin
                w_sel_din = S_DIN[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_sel_valid = w_valid_pad[r_sel];
    assign w_out_free  = !r_ovalid || iREADY;
    assign w_xfer      = (r_state == c_ST_LOCK) && w_sel_valid && w_out_free;
    assign w_is_hdr    = (w_sel_din[DATA_WIDTH-1 -: 8] == HEADER_ID);
    assign w_is_ftr    = (w_sel_din[DATA_WIDTH-1 -: 8] == FOOTER_ID);
    assign w_wcnt_inc  = r_wcnt + c_WCNT_ONE;

    // Ready depends only on state, the output register and iREADY, never on
    // S_VALID, so upstream handshakes cannot form a combinational loop.
    always_comb begin
        w_s_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_s_ready[k] = (r_state == c_ST_LOCK) && w_out_free && (r_sel == 4'(k));
        end
    end

    always_ff @(posedge RD_CLK) begin
        if (RD_RESET) begin
            r_state       <= c_ST_IDLE;
            r_sel         <= '0;
            r_rr_ptr      <= '0;
            r_first       <= 1'b0;
            r_wcnt        <= '0;
            r_dout        <= '0;
            r_ovalid      <= 1'b0;
            r_frame_cnt   <= '0;
            r_drop_cnt    <= '0;
            r_timeout_cnt <= '0;
        end else begin
            // Consumed word leaves the register unless a new one replaces it below.
            if (r_ovalid && iREADY) begin
                r_ovalid <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_sel    <= w_pick;
                        r_rr_ptr <= w_pick_next;
                        r_first  <= 1'b1;
                        r_wcnt   <= '0;
                        r_state  <= c_ST_LOCK;
                    end
                end

                c_ST_LOCK: begin
                    if (w_xfer) begin
                        if (r_first) begin
                            if (!w_is_hdr) begin
                                r_drop_cnt <= sat_inc(r_drop_cnt);
                                r_state    <= c_ST_IDLE;
                            end else begin
                                r_dout   <= w_sel_din;
                                r_ovalid <= 1'b1;
                                r_first  <= 1'b0;
                                r_wcnt   <= c_WCNT_ONE;
                            end
                        end else begin
                            r_dout   <= w_sel_din;
                            r_ovalid <= 1'b1;
                            r_wcnt   <= w_wcnt_inc;
                            // Footer takes priority over the length limit.
                            if (w_is_ftr) begin
                                r_frame_cnt <= sat_inc(r_frame_cnt);
                                r_state     <= c_ST_IDLE;
                            end else if (w_wcnt_inc == c_WCNT_MAX) begin
                                r_state <= c_ST_TERM;
                            end
                        end
                    end
                end

                c_ST_TERM: begin
                    if (w_out_free) begin
                        r_dout        <= c_ERR_FOOTER;
                        r_ovalid      <= 1'b1;
                        r_timeout_cnt <= sat_inc(r_timeout_cnt);
                        r_state       <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign S_READY     = w_s_ready;
    assign DOUT        = r_dout;
    assign oVALID      = r_ovalid;
    assign CUR_CH      = r_sel;
    assign FRAME_CNT   = r_frame_cnt;
    assign DROP_CNT    = r_drop_cnt;
    assign TIMEOUT_CNT = r_timeout_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trigger_frame_merger.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_trigger_frame_merger
//  Purpose  : Self-checking bench for trigger_frame_merger. A table of frame
//             scenarios is applied through per-channel word queues; merged
//             output is compared against an expected word stream and
//             hand-computed counter deltas. Hand-written sequences cover
//             reset, held-off iREADY, round-robin order and counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_frame_merger;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*64-1:0] s_din;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_ready;
    logic [63:0]    dout;
    logic           ovalid;
    logic           iready;
    logic [3:0]     cur_ch;
    logic [15:0]    frame_cnt, drop_cnt, to_cnt;

    // Second instance with 2-bit counters fed a constant junk word.
    logic [127:0]   s_din2 = {64'h0, 64'h1234_5678_0000_0001};
    logic [1:0]     s_valid2 = 2'b01;
    logic [1:0]     s_ready2;
    logic [63:0]    dout2;
    logic           ovalid2;
    logic           iready2 = 1'b1;
    logic [3:0]     cur_ch2;
    logic [1:0]     frame2, drop2, to2;

    always #5 clk = ~clk;

    trigger_frame_merger #(.N_CH(N), .CNT_WIDTH(16)) dut (
        .RD_CLK(clk), .RD_RESET(rst), .S_DIN(s_din), .S_VALID(s_valid),
        .S_READY(s_ready), .DOUT(dout), .oVALID(ovalid), .iREADY(iready),
        .CUR_CH(cur_ch), .FRAME_CNT(frame_cnt), .DROP_CNT(drop_cnt),
        .TIMEOUT_CNT(to_cnt)
    );

    trigger_frame_merger #(.N_CH(2), .CNT_WIDTH(2)) dut2 (
        .RD_CLK(clk), .RD_RESET(rst), .S_DIN(s_din2), .S_VALID(s_valid2),
        .S_READY(s_ready2), .DOUT(dout2), .oVALID(ovalid2), .iREADY(iready2),
        .CUR_CH(cur_ch2), .FRAME_CNT(frame2), .DROP_CNT(drop2),
        .TIMEOUT_CNT(to2)
    );

    typedef struct {
        int cyc;
        logic [63:0] w;
    } log_t;

    typedef struct {
        int ch;
        int n_data;
        bit hdr;
        bit ftr;
        bit mid_hdr;
        int rdy;       // 0: always ready, 1: toggle, 2: held low
        int exp_out;   // words expected on the output
        int d_frame;
        int d_drop;
        int d_to;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] chq [N][$];
    log_t        in_log[$];
    logic [63:0] out_log[$];
    logic [63:0] wbuf[$];
    logic [63:0] exp_q[$];
    int          cyc = 0;
    int          rdy_mode = 0;
    int          ov_first = -1;
    bit          hold_v = 1'b0;
    logic [63:0] hold_d = '0;
    vec_t        tbl[8];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Upstream sources, downstream sink and stall monitor, all at negedge.
    initial begin
        s_valid = '0;
        s_din   = '0;
        iready  = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (hold_v && !rst) begin
                checks++;
                if (ovalid !== 1'b1 || dout !== hold_d) begin
                    failures++;
                    $display("FAIL stall_hold actual=%b/%h required=1/%h", ovalid, dout, hold_d);
                end
            end
            for (int k = 0; k < N; k++) begin
                if (chq[k].size() > 0) begin
                    s_valid[k] = 1'b1;
                    s_din[k*64 +: 64] = chq[k][0];
                end else begin
                    s_valid[k] = 1'b0;
                    s_din[k*64 +: 64] = '0;
                end
            end
            case (rdy_mode)
                0:       iready = 1'b1;
                1:       iready = (cyc % 2) == 1;
                default: iready = 1'b0;
            endcase
            #1;
            for (int k = 0; k < N; k++) begin
                if (s_valid[k] && s_ready[k] === 1'b1) begin
                    in_log.push_back('{cyc, chq[k][0]});
                    void'(chq[k].pop_front());
                end
            end
            if (ovalid === 1'b1 && ov_first < 0) ov_first = cyc;
            if (ovalid === 1'b1 && iready) out_log.push_back(dout);
            hold_v = (ovalid === 1'b1) && !iready && !rst;
            hold_d = dout;
        end
    end

    task automatic clear_logs();
        in_log.delete();
        out_log.delete();
        exp_q.delete();
        ov_first = -1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        rst = 1'b1;
        for (int k = 0; k < N; k++) chq[k].delete();
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic make_frame(input int vid, input int ch, input int n_data,
                              input bit hdr, input bit ftr, input bit mid_hdr);
        wbuf.delete();
        if (hdr) wbuf.push_back({8'hAA, 8'(ch), 16'(vid), 32'hC0DE_0000});
        for (int j = 0; j < n_data; j++) begin
            if (mid_hdr && j == 0)
                wbuf.push_back({8'hAA, 8'hD0, 8'(ch), 8'(vid), 32'(j)});
            else
                wbuf.push_back({8'h12, 8'h34, 8'(ch), 8'(vid), 32'(j)});
        end
        if (ftr) wbuf.push_back({8'h55, 8'(ch), 16'(vid), 32'hF00D_0000});
    endtask

    // Expected forwarded words for the frame in wbuf.
    task automatic model_append();
        int n;
        n = 0;
        if (wbuf.size() == 0 || wbuf[0][63:56] != 8'hAA) return;
        foreach (wbuf[i]) begin
            exp_q.push_back(wbuf[i]);
            n++;
            if (i > 0 && wbuf[i][63:56] == 8'h55) return;
            if (n == 128) begin
                exp_q.push_back(64'h55EE_0000_0000_0000);
                return;
            end
        end
    endtask

    task automatic push_frame(input int ch);
        foreach (wbuf[i]) chq[ch].push_back(wbuf[i]);
    endtask

    task automatic wait_quiet(input int limit);
        int idle;
        int n;
        bit empty;
        idle = 0;
        n = 0;
        while (idle < 4 && n < limit) begin
            @(posedge clk); #2;
            n++;
            empty = 1'b1;
            for (int k = 0; k < N; k++) if (chq[k].size() != 0) empty = 1'b0;
            if (empty && ovalid === 1'b0) idle++; else idle = 0;
        end
        checks++;
        if (idle < 4) begin
            failures++;
            $display("FAIL quiet_timeout actual=busy required=idle_within_%0d", limit);
        end
    endtask

    task automatic cmp_stream(input string tag);
        int bad;
        bad = -1;
        checks++;
        if (out_log.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_len actual=%0d required=%0d", tag, out_log.size(), exp_q.size());
        end else begin
            foreach (out_log[i]) if (bad < 0 && out_log[i] !== exp_q[i]) bad = i;
            if (bad >= 0) begin
                failures++;
                $display("FAIL %s_word[%0d] actual=%h required=%h", tag, bad, out_log[bad], exp_q[bad]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] f0, d0, t0;
        vec_t v;
        rst = 1'b1;
        //          ch n   hdr   ftr   mid   rdy out frm drp to
        tbl[0] = '{0, 10,  1'b1, 1'b1, 1'b0, 0, 12,  1, 0,  0};
        tbl[1] = '{1, 18,  1'b1, 1'b1, 1'b0, 1, 20,  1, 0,  0};
        tbl[2] = '{2, 1,   1'b0, 1'b0, 1'b0, 0, 0,   0, 1,  0};
        tbl[3] = '{2, 200, 1'b1, 1'b0, 1'b0, 0, 129, 0, 73, 1};
        tbl[4] = '{3, 126, 1'b1, 1'b1, 1'b0, 0, 128, 1, 0,  0};
        tbl[5] = '{3, 127, 1'b1, 1'b1, 1'b0, 1, 129, 0, 1,  1};
        tbl[6] = '{0, 0,   1'b1, 1'b1, 1'b0, 1, 2,   1, 0,  0};
        tbl[7] = '{1, 3,   1'b1, 1'b1, 1'b1, 0, 5,   1, 0,  0};

        // Power-up reset values.
        do_reset(5);
        @(posedge clk); #2;
        check64("rst_ovalid", 64'(ovalid), 64'd0);
        check64("rst_sready", 64'(s_ready), 64'd0);
        check64("rst_dout", dout, 64'd0);
        check64("rst_counters", {16'd0, frame_cnt, drop_cnt, to_cnt}, 64'd0);
        check64("rst_cur_ch", 64'(cur_ch), 64'd0);

        // Frame scenario table.
        for (int t = 0; t < 8; t++) begin
            v = tbl[t];
            f0 = frame_cnt;
            d0 = drop_cnt;
            t0 = to_cnt;
            clear_logs();
            rdy_mode = v.rdy;
            make_frame(t, v.ch, v.n_data, v.hdr, v.ftr, v.mid_hdr);
            model_append();
            push_frame(v.ch);
            wait_quiet(1500);
            check64($sformatf("v%0d_out_count", t), 64'(out_log.size()), 64'(v.exp_out));
            cmp_stream($sformatf("v%0d_stream", t));
            check64($sformatf("v%0d_frame_delta", t), 64'(frame_cnt - f0), 64'(v.d_frame));
            check64($sformatf("v%0d_drop_delta", t), 64'(drop_cnt - d0), 64'(v.d_drop));
            check64($sformatf("v%0d_timeout_delta", t), 64'(to_cnt - t0), 64'(v.d_to));
            check64($sformatf("v%0d_cur_ch", t), 64'(cur_ch), 64'(v.ch));
            if (v.hdr) begin
                checks++;
                if (in_log.size() == 0 || ov_first - in_log[0].cyc != 1) begin
                    failures++;
                    $display("FAIL v%0d_latency actual=%0d required=1", t,
                             (in_log.size() == 0) ? -1 : ov_first - in_log[0].cyc);
                end
            end
            if (v.rdy == 0 && v.hdr && v.ftr) begin
                checks++;
                if (in_log.size() != wbuf.size() ||
                    in_log[in_log.size()-1].cyc - in_log[0].cyc != wbuf.size() - 1) begin
                    failures++;
                    $display("FAIL v%0d_throughput actual=%0d_words required=%0d_consecutive",
                             t, in_log.size(), wbuf.size());
                end
            end
        end

        // iREADY held low: one word buffered, then all readies drop.
        clear_logs();
        rdy_mode = 2;
        make_frame(20, 1, 4, 1'b1, 1'b1, 1'b0);
        model_append();
        push_frame(1);
        repeat (10) @(posedge clk);
        #2;
        check64("hold_ovalid", 64'(ovalid), 64'd1);
        check64("hold_sready", 64'(s_ready), 64'd0);
        check64("hold_dout", dout, wbuf[0]);
        check64("hold_consumed", 64'(chq[1].size()), 64'(wbuf.size() - 1));
        rdy_mode = 0;
        wait_quiet(200);
        cmp_stream("hold_stream");

        // Round-robin from pointer 0 with ch0, ch1, ch3 pending together.
        do_reset(2);
        rdy_mode = 0;
        make_frame(30, 0, 2, 1'b1, 1'b1, 1'b0); model_append(); push_frame(0);
        make_frame(31, 1, 2, 1'b1, 1'b1, 1'b0); model_append(); push_frame(1);
        make_frame(33, 3, 2, 1'b1, 1'b1, 1'b0); model_append(); push_frame(3);
        wait_quiet(300);
        cmp_stream("rr_order");
        checks++;
        if (in_log.size() < 5 || in_log[4].cyc - in_log[3].cyc != 2) begin
            failures++;
            $display("FAIL rr_footer_to_header actual=%0d required=2",
                     (in_log.size() < 5) ? -1 : in_log[4].cyc - in_log[3].cyc);
        end
        // Pointer has wrapped past ch3, so ch0 goes before ch2.
        clear_logs();
        make_frame(35, 0, 2, 1'b1, 1'b1, 1'b0); model_append(); push_frame(0);
        make_frame(34, 2, 2, 1'b1, 1'b1, 1'b0); model_append(); push_frame(2);
        wait_quiet(300);
        cmp_stream("rr_refill");
        check64("rr_cur_ch", 64'(cur_ch), 64'd2);

        // Reset in the middle of a frame.
        clear_logs();
        rdy_mode = 1;
        make_frame(40, 3, 100, 1'b1, 1'b1, 1'b0);
        push_frame(3);
        repeat (20) @(posedge clk);
        do_reset(5);
        @(posedge clk); #2;
        check64("mid_rst_ovalid", 64'(ovalid), 64'd0);
        check64("mid_rst_sready", 64'(s_ready), 64'd0);
        check64("mid_rst_dout", dout, 64'd0);
        check64("mid_rst_counters", {16'd0, frame_cnt, drop_cnt, to_cnt}, 64'd0);
        check64("mid_rst_cur_ch", 64'(cur_ch), 64'd0);
        rdy_mode = 0;
        repeat (30) @(posedge clk);
        #2;
        check64("mid_rst_no_footer", 64'(out_log.size()), 64'd0);

        // Saturating counter in the small instance, sampled one drop apart.
        check64("sat_drop_a", 64'(drop2), 64'd3);
        repeat (2) @(posedge clk);
        #2;
        check64("sat_drop_b", 64'(drop2), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
